// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the ROM burst arbiter.
package rom_arb_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/rom_rr_arbiter.sv
// Two-way round-robin pick: returns the one-hot winner of req.
// On a tie, prio names the favoured requester.
module rom_rr_arbiter (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] win
);

  // Winner selection; a lone request always wins
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = prio ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Arbitrates two burst readers onto one asynchronous ROM and returns
// the words as a registered stream tagged with the owner id.
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  req,
  input  logic [2*ADDR_WIDTH-1:0]     start_addr,
  input  logic [2*(ADDR_WIDTH+1)-1:0] len,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  input  logic [DATA_WIDTH-1:0]       rom_q,
  output logic [1:0]                  gnt,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        rd_id,
  output logic [1:0]                  done
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO_C = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic                    prio_r;
  logic                    owner_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH:0]     cnt_r;
  logic [1:0]              gnt_r;
  logic [1:0]              done_r;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic                    rd_valid_r;
  logic                    rd_id_r;

  logic [1:0]              win_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [ADDR_WIDTH:0]     sel_len_s;
  logic [ADDR_WIDTH:0]     len_clamp_s;

  rom_rr_arbiter u_rr (
    .req  (req),
    .prio (prio_r),
    .win  (win_s)
  );

  // Pick the winner's request fields and clamp the length to the ROM depth
  always_comb begin
    sel_addr_s  = start_addr[ADDR_WIDTH-1:0];
    sel_len_s   = len[ADDR_WIDTH:0];
    len_clamp_s = CNT_ZERO_C;
    if (win_s[1]) begin
      sel_addr_s = start_addr[ADDR_WIDTH +: ADDR_WIDTH];
      sel_len_s  = len[(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)];
    end else begin
      sel_addr_s = start_addr[ADDR_WIDTH-1:0];
      sel_len_s  = len[ADDR_WIDTH:0];
    end
    if (sel_len_s > DEPTH_C) begin
      len_clamp_s = DEPTH_C;
    end else begin
      len_clamp_s = sel_len_s;
    end
  end

  // Burst FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      prio_r     <= 1'b0;
      owner_r    <= 1'b0;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      cnt_r      <= CNT_ZERO_C;
      gnt_r      <= 2'b00;
      done_r     <= 2'b00;
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
      rd_id_r    <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      done_r     <= 2'b00;
      case (state_r)
        IDLE: begin
          if (|req) begin
            owner_r <= win_s[1];
            gnt_r   <= win_s;
            cnt_r   <= len_clamp_s;
            if (len_clamp_s == CNT_ZERO_C) begin
              // Empty burst: report completion without touching the ROM
              state_r <= DONE;
              done_r  <= win_s;
            end else begin
              state_r <= BURST;
              addr_r  <= sel_addr_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BURST: begin
          rd_data_r  <= rom_q;
          rd_valid_r <= 1'b1;
          rd_id_r    <= owner_r;
          cnt_r      <= cnt_r - CNT_ONE_C;
          if (cnt_r == CNT_ONE_C) begin
            state_r <= DONE;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            done_r  <= {owner_r, ~owner_r};
          end else begin
            state_r <= BURST;
            addr_r  <= addr_r + ADDR_ONE_C;
          end
        end
        DONE: begin
          state_r <= IDLE;
          gnt_r   <= 2'b00;
          prio_r  <= ~owner_r;
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 2'b00;
          addr_r  <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign rom_addr = addr_r;
  assign gnt      = gnt_r;
  assign done     = done_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_id    = rd_id_r;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter against a ROM holding mem[a] = 8'h10 + a.
module tb_rom_burst_arbiter;

  logic       tb_clk;
  logic       reset;
  logic [1:0] req;
  logic [5:0] start_addr;
  logic [7:0] len;
  logic [2:0] rom_addr;
  logic [7:0] rom_q;
  logic [1:0] gnt;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_id;
  logic [1:0] done;
  logic [7:0] mem [0:7];

  int vectors;
  int miscompares;

  rom_burst_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk        (tb_clk),
    .reset      (reset),
    .req        (req),
    .start_addr (start_addr),
    .len        (len),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .gnt        (gnt),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_id      (rd_id),
    .done       (done)
  );

  assign rom_q = mem[rom_addr];

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic tick;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; req = 2'b00; start_addr = 6'd0; len = 8'd0;
    repeat (2) @(posedge tb_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 2'b11; start_addr = 6'd0; len = 8'd0;
    #1;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    vectors++; if (done !== 2'b00) begin miscompares++; $display("FAIL rst_done: got %b want 00", done); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
    vectors++; if (rd_id !== 1'b0) begin miscompares++; $display("FAIL rst_id: got %b want 0", rd_id); end
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h want 00", rd_data); end
    vectors++; if (rom_addr !== 3'd0) begin miscompares++; $display("FAIL rst_addr: got %0d want 0", rom_addr); end
    tick;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rst_hold_gnt: got %b want 00", gnt); end
    reset = 1'b0; req = 2'b00;
  endtask

  task automatic test_single;
    logic [7:0] exp_d [0:2];
    exp_d[0] = 8'h12; exp_d[1] = 8'h13; exp_d[2] = 8'h14;
    apply_reset;
    req = 2'b01; start_addr = {3'd0, 3'd2}; len = {4'd0, 4'd3};
    tick;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL s1_gnt: got %b want 01", gnt); end
    vectors++; if (rom_addr !== 3'd2) begin miscompares++; $display("FAIL s1_addr: got %0d want 2", rom_addr); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL s1_early_valid: got %b want 0", rd_valid); end
    for (int k = 0; k < 3; k++) begin
      tick;
      vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL s1_valid beat %0d: got %b want 1", k, rd_valid); end
      vectors++; if (rd_data !== exp_d[k]) begin miscompares++; $display("FAIL s1_data beat %0d: got %h want %h", k, rd_data, exp_d[k]); end
      vectors++; if (rd_id !== 1'b0) begin miscompares++; $display("FAIL s1_id beat %0d: got %b want 0", k, rd_id); end
      vectors++; if (done !== ((k == 2) ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL s1_done beat %0d: got %b", k, done); end
      vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL s1_gnt_hold beat %0d: got %b want 01", k, gnt); end
    end
    tick;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL s1_idle_gnt: got %b want 00", gnt); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL s1_idle_valid: got %b want 0", rd_valid); end
    vectors++; if (done !== 2'b00) begin miscompares++; $display("FAIL s1_idle_done: got %b want 00", done); end
    vectors++; if (rom_addr !== 3'd0) begin miscompares++; $display("FAIL s1_idle_addr: got %0d want 0", rom_addr); end
    req = 2'b00;
  endtask

  task automatic test_wrap;
    logic [7:0] exp_d [0:3];
    exp_d[0] = 8'h16; exp_d[1] = 8'h17; exp_d[2] = 8'h10; exp_d[3] = 8'h11;
    apply_reset;
    req = 2'b10; start_addr = {3'd6, 3'd0}; len = {4'd4, 4'd0};
    tick;
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL wrap_gnt: got %b want 10", gnt); end
    req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick;
      vectors++; if (rd_data !== exp_d[k] || rd_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_data beat %0d: got %h/%b want %h/1", k, rd_data, rd_valid, exp_d[k]); end
      vectors++; if (rd_id !== 1'b1) begin miscompares++; $display("FAIL wrap_id beat %0d: got %b want 1", k, rd_id); end
      vectors++; if (done !== ((k == 3) ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL wrap_done beat %0d: got %b", k, done); end
    end
    tick;
    vectors++; if (rd_valid !== 1'b0 || gnt !== 2'b00) begin miscompares++; $display("FAIL wrap_end: got valid %b gnt %b want 0/00", rd_valid, gnt); end
  endtask

  task automatic test_alternate;
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    apply_reset;
    req = 2'b11; start_addr = {3'd4, 3'd0}; len = {4'd1, 4'd1};
    for (int b = 0; b < 4; b++) begin
      exp_g = (b % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (b % 2 == 0) ? 8'h10 : 8'h14;
      tick;
      vectors++; if (gnt !== exp_g) begin miscompares++; $display("FAIL alt_gnt burst %0d: got %b want %b", b, gnt, exp_g); end
      tick;
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin miscompares++; $display("FAIL alt_data burst %0d: got %h/%b want %h/1", b, rd_data, rd_valid, exp_d); end
      vectors++; if (done !== exp_g) begin miscompares++; $display("FAIL alt_done burst %0d: got %b want %b", b, done, exp_g); end
      vectors++; if (rd_id !== exp_g[1]) begin miscompares++; $display("FAIL alt_id burst %0d: got %b want %b", b, rd_id, exp_g[1]); end
      tick;
      vectors++; if (gnt !== 2'b00 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL alt_idle burst %0d: got gnt %b valid %b want 00/0", b, gnt, rd_valid); end
    end
    req = 2'b00;
  endtask

  task automatic test_len_zero;
    apply_reset;
    req = 2'b01; start_addr = {3'd0, 3'd3}; len = {4'd0, 4'd0};
    tick;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL len0_gnt: got %b want 01", gnt); end
    vectors++; if (done !== 2'b01) begin miscompares++; $display("FAIL len0_done: got %b want 01", done); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL len0_valid: got %b want 0", rd_valid); end
    vectors++; if (rom_addr !== 3'd0) begin miscompares++; $display("FAIL len0_addr: got %0d want 0", rom_addr); end
    req = 2'b00;
    tick;
    vectors++; if (gnt !== 2'b00 || done !== 2'b00 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL len0_idle: got gnt %b done %b valid %b want 00/00/0", gnt, done, rd_valid); end
  endtask

  task automatic test_clamp;
    logic [7:0] exp_d [0:7];
    exp_d[0] = 8'h13; exp_d[1] = 8'h14; exp_d[2] = 8'h15; exp_d[3] = 8'h16;
    exp_d[4] = 8'h17; exp_d[5] = 8'h10; exp_d[6] = 8'h11; exp_d[7] = 8'h12;
    apply_reset;
    req = 2'b10; start_addr = {3'd3, 3'd0}; len = {4'd15, 4'd0};
    tick;
    req = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick;
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_d[k]) begin miscompares++; $display("FAIL clamp_data beat %0d: got %h/%b want %h/1", k, rd_data, rd_valid, exp_d[k]); end
      vectors++; if (done !== ((k == 7) ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL clamp_done beat %0d: got %b", k, done); end
    end
    tick;
    vectors++; if (rd_valid !== 1'b0 || gnt !== 2'b00) begin miscompares++; $display("FAIL clamp_end: got valid %b gnt %b want 0/00", rd_valid, gnt); end
  endtask

  task automatic test_req_drop;
    logic [7:0] exp_d [0:2];
    exp_d[0] = 8'h15; exp_d[1] = 8'h16; exp_d[2] = 8'h17;
    apply_reset;
    req = 2'b01; start_addr = {3'd0, 3'd5}; len = {4'd0, 4'd3};
    tick;
    req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick;
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_d[k]) begin miscompares++; $display("FAIL drop_data beat %0d: got %h/%b want %h/1", k, rd_data, rd_valid, exp_d[k]); end
      vectors++; if (done !== ((k == 2) ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL drop_done beat %0d: got %b", k, done); end
    end
    tick;
    vectors++; if (gnt !== 2'b00 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL drop_end: got gnt %b valid %b want 00/0", gnt, rd_valid); end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    req = 2'b01; start_addr = {3'd5, 3'd1}; len = {4'd2, 4'd5};
    tick;
    tick;
    tick;
    vectors++; if (rd_data !== 8'h12 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL mid_beat2: got %h/%b want 12/1", rd_data, rd_valid); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (gnt !== 2'b00 || done !== 2'b00) begin miscompares++; $display("FAIL mid_async_ctl: got gnt %b done %b want 00/00", gnt, done); end
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || rom_addr !== 3'd0) begin miscompares++; $display("FAIL mid_async_data: got %b/%h/%0d want 0/00/0", rd_valid, rd_data, rom_addr); end
    @(negedge tb_clk);
    reset = 1'b0; req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick;
      vectors++; if (done !== 2'b00 || rd_valid !== 1'b0 || gnt !== 2'b00) begin miscompares++; $display("FAIL mid_quiet %0d: got done %b valid %b gnt %b", k, done, rd_valid, gnt); end
    end
    req = 2'b10;
    tick;
    vectors++; if (gnt !== 2'b10 || rom_addr !== 3'd5) begin miscompares++; $display("FAIL mid_new_grant: got gnt %b addr %0d want 10/5", gnt, rom_addr); end
    req = 2'b00;
    tick;
    vectors++; if (rd_data !== 8'h15 || rd_id !== 1'b1 || done !== 2'b00) begin miscompares++; $display("FAIL mid_new_beat0: got %h id %b done %b want 15/1/00", rd_data, rd_id, done); end
    tick;
    vectors++; if (rd_data !== 8'h16 || done !== 2'b10) begin miscompares++; $display("FAIL mid_new_beat1: got %h done %b want 16/10", rd_data, done); end
    tick;
    vectors++; if (gnt !== 2'b00 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_new_end: got gnt %b valid %b want 00/0", gnt, rd_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    test_reset;
    test_single;
    test_wrap;
    test_alternate;
    test_len_zero;
    test_clamp;
    test_req_drop;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
